// File: rtl/sincos_pipe.sv
// rtl/sincos_pipe.sv - pipelined quarter-wave sine/cosine generator with valid/ready handshake
// Optional build macro SINCOS_PIPE_INTERP_EN adds a linear-interpolation stage (latency 4 instead of 3).
module sincos_pipe #(
  parameter int ANGLE_W = 9,
  parameter int OUT_W   = 8,
  parameter int SCALE   = 64,
  parameter int STEP    = 5,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ANGLE_W-1:0] in_angle,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_sin,
  output logic [OUT_W-1:0]   out_cos,
  output logic               out_err,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int N  = 90 / STEP + 1;
  localparam int IW = $clog2(N);
  localparam int TW = N * OUT_W;

  // Q30 Taylor series keeps the table build in integer arithmetic; every entry lies in 0..SCALE.
  function automatic logic [TW-1:0] build_tbl();
    logic [TW-1:0] t;
    longint x, term, sum, v;
    t = '0;
    for (int k = 0; k < N; k++) begin
      x    = (longint'(k * STEP) * 64'sd3373259426) / 64'sd180;
      sum  = x;
      term = x;
      for (int n = 1; n <= 8; n++) begin
        term = (term * x) >>> 30;
        term = (term * x) >>> 30;
        term = -term / longint'((2 * n) * (2 * n + 1));
        sum  = sum + term;
      end
      v = (longint'(SCALE) * sum + (64'sd1 <<< 29)) >>> 30;
      t[k*OUT_W +: OUT_W] = OUT_W'(v);
    end
    return t;
  endfunction

  localparam logic [TW-1:0] TBL = build_tbl();

  function automatic logic [OUT_W-1:0] tbl_at(input int idx);
    return TBL[idx*OUT_W +: OUT_W];
  endfunction

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv | !rst_n;

  // Stage 1: quadrant fold by comparison
  logic [31:0]      a32;
  logic [1:0]       q1_d, q1;
  logic [6:0]       r1_d, r1;
  logic             e1, v1;
  logic [TAG_W-1:0] tag1;

  assign a32 = 32'(in_angle);

  always_comb begin
    q1_d = 2'd0;
    r1_d = 7'(a32);
    if (a32 >= 32'd270) begin
      q1_d = 2'd3;
      r1_d = 7'(a32 - 32'd270);
    end else if (a32 >= 32'd180) begin
      q1_d = 2'd2;
      r1_d = 7'(a32 - 32'd180);
    end else if (a32 >= 32'd90) begin
      q1_d = 2'd1;
      r1_d = 7'(a32 - 32'd90);
    end
  end

  // Stage 2: table index lookup
  logic [IW-1:0]    i_d;
  int               ii;
  logic [OUT_W-1:0] s_d, c_d, s2, c2;
  logic [1:0]       q2;
  logic             e2, v2;
  logic [TAG_W-1:0] tag2;

  always_comb begin
    i_d = '0;
    for (int k = 1; k < N; k++) begin
      if (int'(r1) >= k * STEP) i_d = IW'(k);
    end
    ii  = int'(i_d);
    s_d = tbl_at(ii);
    c_d = tbl_at(N - 1 - ii);
  end

  logic [1:0]       qm;
  logic             em, vm;
  logic [TAG_W-1:0] tagm;
  logic [OUT_W-1:0] sm, cm;

`ifdef SINCOS_PIPE_INTERP_EN
  logic [OUT_W-1:0] sn_d, cp_d, sn2, cp2;
  logic [6:0]       f_d, f2;
  logic [OUT_W-1:0] si_d, ci_d, s3, c3;
  logic [1:0]       q3;
  logic             e3, v3;
  logic [TAG_W-1:0] tag3;
  int               ds, dc;

  // Neighbour indices clamp so out-of-range residues from error angles stay inside the table.
  always_comb begin
    sn_d = tbl_at((ii + 1 > N - 1) ? N - 1 : ii + 1);
    cp_d = tbl_at((N - 2 - ii < 0) ? 0 : N - 2 - ii);
    f_d  = 7'(int'(r1) - ii * STEP);
  end

  always_comb begin
    ds   = int'(sn2) - int'(s2);
    dc   = int'(c2) - int'(cp2);
    si_d = OUT_W'(int'(s2) + (ds * int'(f2) + STEP / 2) / STEP);
    ci_d = OUT_W'(int'(c2) - (dc * int'(f2) + STEP / 2) / STEP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) v3 <= 1'b0;
    else if (adv) v3 <= v2;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      sn2  <= sn_d;
      cp2  <= cp_d;
      f2   <= f_d;
      s3   <= si_d;
      c3   <= ci_d;
      q3   <= q2;
      e3   <= e2;
      tag3 <= tag2;
    end
  end

  assign vm   = v3;
  assign qm   = q3;
  assign em   = e3;
  assign tagm = tag3;
  assign sm   = s3;
  assign cm   = c3;
`else
  assign vm   = v2;
  assign qm   = q2;
  assign em   = e2;
  assign tagm = tag2;
  assign sm   = s2;
  assign cm   = c2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      q1   <= q1_d;
      r1   <= r1_d;
      e1   <= (a32 >= 32'd360);
      tag1 <= in_tag;
      s2   <= s_d;
      c2   <= c_d;
      q2   <= q1;
      e2   <= e1;
      tag2 <= tag1;
    end
  end

  // Output stage: quadrant mapping, error forces zero
  logic [OUT_W-1:0] so_d, co_d;

  always_comb begin
    so_d = sm;
    co_d = cm;
    case (qm)
      2'd1: begin so_d = cm;  co_d = -sm; end
      2'd2: begin so_d = -sm; co_d = -cm; end
      2'd3: begin so_d = -cm; co_d = sm;  end
      default: begin so_d = sm; co_d = cm; end
    endcase
    if (em) begin
      so_d = '0;
      co_d = '0;
    end
  end

  // Data only loads with a valid sample so a bubble never disturbs a held result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sin   <= '0;
      out_cos   <= '0;
      out_err   <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= vm;
      if (vm) begin
        out_sin <= so_d;
        out_cos <= co_d;
        out_err <= em;
        out_tag <= tagm;
      end
    end
  end

endmodule

// File: tb/tb_sincos_pipe.sv
// tb/tb_sincos_pipe.sv - directed self-checking bench for sincos_pipe
module tb_sincos_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_angle = '0;
  logic [3:0] in_tag = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sin, out_cos;
  logic       out_err;
  logic [3:0] out_tag;

`ifdef SINCOS_PIPE_INTERP_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int q_sin[$], q_cos[$], q_err[$], q_tag[$], q_cyc[$];
  int tbl[19] = '{0, 6, 11, 17, 22, 27, 32, 37, 41, 45, 49, 52, 55, 58, 60, 62, 63, 64, 64};

  sincos_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sin(out_sin), .out_cos(out_cos),
    .out_err(out_err), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer that the next rising edge will complete.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q_sin.push_back(int'($signed(out_sin)));
      q_cos.push_back(int'($signed(out_cos)));
      q_err.push_back(int'(out_err));
      q_tag.push_back(int'(out_tag));
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_sin.delete(); q_cos.delete(); q_err.delete(); q_tag.delete(); q_cyc.delete();
  endtask

  task automatic send(input int a, input int t);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_angle = 9'(a);
    in_tag   = 4'(t);
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL send_accept angle=%0d got=not_accepted exp=accepted", a); end
  endtask

  task automatic wait_q(input int n);
    int k;
    k = 0;
    while (q_sin.size() < n && k < 300) begin tick(); k++; end
    checks++;
    if (q_sin.size() < n) begin failures++; $display("FAIL wait_results got=%0d exp=%0d", q_sin.size(), n); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || out_sin !== 8'd0 || out_cos !== 8'd0 || out_err !== 1'b0 || out_tag !== 4'd0) begin
      failures++;
      $display("FAIL reset_outputs got=v%b s%0d c%0d e%b t%0d exp=all_zero", out_valid, out_sin, out_cos, out_err, out_tag);
    end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_first_sample();
    out_ready = 1'b1;
    in_valid = 1'b1; in_angle = 9'd0; in_tag = 4'd5;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early edge=%0d got=%b exp=0", c, out_valid); end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || $signed(out_sin) !== 8'sd0 || $signed(out_cos) !== 8'sd64 || out_err !== 1'b0 || out_tag !== 4'd5) begin
      failures++;
      $display("FAIL first_sample got=v%b s%0d c%0d e%b t%0d exp=v1 s0 c64 e0 t5",
               out_valid, $signed(out_sin), $signed(out_cos), out_err, out_tag);
    end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    int a, q, j, es, ec, n;
    clear_q();
    out_ready = 1'b1;
    for (int k = 0; k < 72; k++) send(k * 5, k % 16);
    wait_q(72);
    n = (q_sin.size() < 72) ? q_sin.size() : 72;
    for (int k = 0; k < n; k++) begin
      a = k * 5; q = a / 90; j = (a % 90) / 5;
      case (q)
        0: begin es = tbl[j];       ec = tbl[18 - j];  end
        1: begin es = tbl[18 - j];  ec = -tbl[j];      end
        2: begin es = -tbl[j];      ec = -tbl[18 - j]; end
        default: begin es = -tbl[18 - j]; ec = tbl[j]; end
      endcase
      checks++;
      if (q_sin[k] !== es || q_cos[k] !== ec || q_err[k] !== 0 || q_tag[k] !== k % 16) begin
        failures++;
        $display("FAIL sweep angle=%0d got=s%0d c%0d e%0d t%0d exp=s%0d c%0d e0 t%0d",
                 a, q_sin[k], q_cos[k], q_err[k], q_tag[k], es, ec, k % 16);
      end
      if (k > 0) begin
        checks++;
        if (q_cyc[k] !== q_cyc[k-1] + 1) begin
          failures++; $display("FAIL sweep_throughput idx=%0d got_gap=%0d exp_gap=1", k, q_cyc[k] - q_cyc[k-1]);
        end
      end
    end
    if (n == 72) begin
      checks++; if (q_sin[19] !== 64 || q_cos[19] !== -6) begin failures++; $display("FAIL spot_95 got=%0d,%0d exp=64,-6", q_sin[19], q_cos[19]); end
      checks++; if (q_sin[45] !== -45 || q_cos[45] !== -45) begin failures++; $display("FAIL spot_225 got=%0d,%0d exp=-45,-45", q_sin[45], q_cos[45]); end
      checks++; if (q_sin[71] !== -6 || q_cos[71] !== 64) begin failures++; $display("FAIL spot_355 got=%0d,%0d exp=-6,64", q_sin[71], q_cos[71]); end
    end
  endtask

  task automatic test_off_grid();
    int es, ec;
`ifdef SINCOS_PIPE_INTERP_EN
    es = 39; ec = 51;
`else
    es = 37; ec = 52;
`endif
    clear_q();
    send(37, 3);
    wait_q(1);
    if (q_sin.size() >= 1) begin
      checks++;
      if (q_sin[0] !== es || q_cos[0] !== ec || q_err[0] !== 0 || q_tag[0] !== 3) begin
        failures++; $display("FAIL angle_37 got=s%0d c%0d t%0d exp=s%0d c%0d t3", q_sin[0], q_cos[0], q_tag[0], es, ec);
      end
    end
  endtask

  task automatic test_range_err();
    int ea[3] = '{360, 511, 90};
    int es[3] = '{0, 0, 64};
    int ee[3] = '{1, 1, 0};
    clear_q();
    for (int k = 0; k < 3; k++) send(ea[k], 8 + k);
    wait_q(3);
    for (int k = 0; k < 3 && k < q_sin.size(); k++) begin
      checks++;
      if (q_sin[k] !== es[k] || q_cos[k] !== 0 || q_err[k] !== ee[k] || q_tag[k] !== 8 + k) begin
        failures++;
        $display("FAIL range_err angle=%0d got=s%0d c%0d e%0d t%0d exp=s%0d c0 e%0d t%0d",
                 ea[k], q_sin[k], q_cos[k], q_err[k], q_tag[k], es[k], ee[k], 8 + k);
      end
    end
  endtask

  task automatic test_stall();
    int ang[10] = '{10, 20, 45, 100, 135, 180, 200, 270, 300, 330};
    int es[10]  = '{11, 22, 45, 63, 45, 0, -22, -64, -55, -32};
    int ec[10]  = '{63, 60, 45, -11, -45, -64, -60, 0, 32, 55};
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] ps, pc;
    logic [3:0] pt;
    bit pstall;
    int c;
    clear_q();
    pstall = 1'b0;
    c = 0;
    fork
      begin
        for (int k = 0; k < 10; k++) send(ang[k], k);
      end
      begin
        while (q_sin.size() < 10 && c < 300) begin
          out_ready = pat[c % 4];
          @(negedge clk);
          checks++;
          if (in_ready !== (!out_valid | out_ready)) begin
            failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=%b", c, in_ready, !out_valid | out_ready);
          end
          if (pstall) begin
            checks++;
            if (out_valid !== 1'b1 || out_sin !== ps || out_cos !== pc || out_tag !== pt) begin
              failures++; $display("FAIL stall_hold cyc=%0d got=s%0d c%0d t%0d exp=s%0d c%0d t%0d", c, out_sin, out_cos, out_tag, ps, pc, pt);
            end
          end
          pstall = out_valid && !out_ready;
          ps = out_sin; pc = out_cos; pt = out_tag;
          tick();
          c++;
        end
      end
    join
    out_ready = 1'b1;
    repeat (8) tick();
    checks++; if (q_sin.size() !== 10) begin failures++; $display("FAIL stall_count got=%0d exp=10", q_sin.size()); end
    for (int k = 0; k < 10 && k < q_sin.size(); k++) begin
      checks++;
      if (q_sin[k] !== es[k] || q_cos[k] !== ec[k] || q_err[k] !== 0 || q_tag[k] !== k) begin
        failures++;
        $display("FAIL stall_data idx=%0d got=s%0d c%0d e%0d t%0d exp=s%0d c%0d e0 t%0d",
                 k, q_sin[k], q_cos[k], q_err[k], q_tag[k], es[k], ec[k], k);
      end
    end
  endtask

  task automatic test_reset_flight();
    int n;
    clear_q();
    out_ready = 1'b1;
    send(10, 1); send(20, 2); send(30, 3);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flight_reset_in_ready got=%b exp=1", in_ready); end
    tick();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flight_reset_valid got=%b exp=0", out_valid); end
    repeat (8) tick();
    checks++; if (q_sin.size() !== 0) begin failures++; $display("FAIL flight_stale got=%0d exp=0", q_sin.size()); end

    out_ready = 1'b0;
    send(45, 7);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (out_valid !== 1'b1 || out_tag !== 4'd7) begin failures++; $display("FAIL stall_held got=v%b t%0d exp=v1 t7", out_valid, out_tag); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0 || out_tag !== 4'd0) begin failures++; $display("FAIL stall_reset got=v%b t%0d exp=v0 t0", out_valid, out_tag); end
    out_ready = 1'b1;
    repeat (6) tick();
    checks++; if (q_sin.size() !== 0) begin failures++; $display("FAIL stall_reset_stale got=%0d exp=0", q_sin.size()); end
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_back_to_back();
    test_off_grid();
    test_range_err();
    test_stall();
    test_reset_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
